max_pool_sequencer: RTL and testbench

- Walks an IMG_H x IMG_W feature map held in a single-port read memory (1-cycle read latency) in 2x2 stride-2 windows.
- For each window: fetches the four pixels, drives them into the existing 4-input max-pooling unit, waits for its done flag, then writes the result to the pooled-output buffer.
- Sits between the conv-layer feature-map buffer and the next layer's input buffer; one start pulse pools a whole map.

---
 rtl/max_pool_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_max_pool_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_sequencer.sv
// max_pool_sequencer: walks an IMG_H x IMG_W feature map in 2x2 stride-2
// windows. For each window it reads four pixels, hands them to the 4-input
// max-pooling unit, waits for its answer and writes it to the output buffer.
// Optional WAIT watchdog: define MAXPOOL_SEQ_TIMEOUT_EN to enable it.
// With the watchdog, TIMEOUT WAIT cycles without pool_done force a zero
// write and set the sticky err flag.
module max_pool_sequencer #(
  parameter int DATA_W  = 22,
  parameter int IMG_W   = 4,
  parameter int IMG_H   = 4,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] pool_in1,
  output logic [DATA_W-1:0] pool_in2,
  output logic [DATA_W-1:0] pool_in3,
  output logic [DATA_W-1:0] pool_in4,
  output logic              pool_enable,
  input  logic [DATA_W-1:0] pool_out,
  input  logic              pool_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              err
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_LAST, S_ISSUE, S_WAIT, S_WRITE, S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] H_A   = ADDR_W'(IMG_H);
  localparam logic [ADDR_W-1:0] HW_A  = ADDR_W'(IMG_W / 2);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO_A = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] W1_A  = ADDR_W'(IMG_W + 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   r_q, c_q;
  logic                busy_q, done_q, rd_en_q, pool_enable_q, wr_en_q;
  logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
  logic [DATA_W-1:0]   pool_in1_q, pool_in2_q, pool_in3_q, pool_in4_q, wr_data_q;

  // Window arithmetic: current base/output index and the next window origin.
  logic [ADDR_W-1:0]   base, out_idx, c_step, r_d, c_d, next_base;
  logic                last_win;

`ifdef MAXPOOL_SEQ_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wait_cnt_q;
  logic        err_q;
`endif

  // Derive addresses of the current window and where the walk goes next.
  always_comb begin
    base      = r_q * W_A + c_q;
    out_idx   = (r_q >> 1) * HW_A + (c_q >> 1);
    c_step    = c_q + TWO_A;
    r_d       = r_q;
    c_d       = c_step;
    last_win  = 1'b0;
    if (c_step == W_A) begin
      c_d      = '0;
      r_d      = r_q + TWO_A;
      last_win = (r_d == H_A);
    end
    next_base = r_d * W_A + c_d;
  end

  // Sequencer FSM; every output is registered and aligned with its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      r_q           <= '0;
      c_q           <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      pool_enable_q <= 1'b0;
      pool_in1_q    <= '0;
      pool_in2_q    <= '0;
      pool_in3_q    <= '0;
      pool_in4_q    <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
`ifdef MAXPOOL_SEQ_TIMEOUT_EN
      wait_cnt_q    <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      rd_en_q       <= 1'b0;
      pool_enable_q <= 1'b0;
      wr_en_q       <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            r_q       <= '0;
            c_q       <= '0;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            state_q   <= S_RD0;
          end
        end
        S_RD0: begin
          rd_en_q   <= 1'b1;
          rd_addr_q <= base + ONE_A;
          state_q   <= S_RD1;
        end
        S_RD1: begin
          pool_in1_q <= rd_data;
          rd_en_q    <= 1'b1;
          rd_addr_q  <= base + W_A;
          state_q    <= S_RD2;
        end
        S_RD2: begin
          pool_in2_q <= rd_data;
          rd_en_q    <= 1'b1;
          rd_addr_q  <= base + W1_A;
          state_q    <= S_RD3;
        end
        S_RD3: begin
          pool_in3_q <= rd_data;
          state_q    <= S_LAST;
        end
        S_LAST: begin
          pool_in4_q    <= rd_data;
          pool_enable_q <= 1'b1;
          state_q       <= S_ISSUE;
        end
        S_ISSUE: begin
`ifdef MAXPOOL_SEQ_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (pool_done) begin
            wr_data_q <= pool_out;
            wr_addr_q <= out_idx;
            wr_en_q   <= 1'b1;
            state_q   <= S_WRITE;
          end
`ifdef MAXPOOL_SEQ_TIMEOUT_EN
          else if (wait_cnt_q == WAIT_LAST) begin
            wr_data_q <= '0;
            wr_addr_q <= out_idx;
            wr_en_q   <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= S_WRITE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
`endif
        end
        S_WRITE: begin
          r_q <= r_d;
          c_q <= c_d;
          if (last_win) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= next_base;
            state_q   <= S_RD0;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign pool_in1    = pool_in1_q;
  assign pool_in2    = pool_in2_q;
  assign pool_in3    = pool_in3_q;
  assign pool_in4    = pool_in4_q;
  assign pool_enable = pool_enable_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

`ifdef MAXPOOL_SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  // No watchdog: err folds to constant 0 for any legal TIMEOUT.
  assign err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_max_pool_sequencer.sv
// Self-checking bench for max_pool_sequencer: memory model, 4-input max
// pooling model and a scoreboard of expected reads, pool inputs and writes.
`timescale 1ns/1ps
module tb_max_pool_sequencer;
  localparam int DATA_W  = 22;
  localparam int IMG_W   = 4;
  localparam int IMG_H   = 4;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int NPIX    = IMG_W * IMG_H;
  // Busy cycles per map: 4 windows * (RD0..ISSUE 6 + 3 WAIT + WRITE 1) + FIN.
  localparam int BUSY_NOM = 41;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, rd_en, pool_enable, pool_done, wr_en, err;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic [DATA_W-1:0] pool_in1, pool_in2, pool_in3, pool_in4, pool_out, wr_data;

  always #5 clk = ~clk;

  max_pool_sequencer #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pool_in1(pool_in1), .pool_in2(pool_in2), .pool_in3(pool_in3), .pool_in4(pool_in4),
    .pool_enable(pool_enable), .pool_out(pool_out), .pool_done(pool_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err(err)
  );

  // Feature-map memory with one-cycle read latency.
  logic [DATA_W-1:0] mem [NPIX];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  function automatic logic [DATA_W-1:0] max4(input logic signed [DATA_W-1:0] a, b, c, d);
    logic signed [DATA_W-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Pooling unit model: registered done two edges after it samples enable.
  logic [1:0] pcnt = '0;
  logic pool_done_model = 1'b0, pool_done_spur = 1'b0, mute = 1'b0;
  logic [DATA_W-1:0] pool_res = '0;
  assign pool_done = pool_done_model | pool_done_spur;
  assign pool_out  = pool_res;
  always @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
      pool_done_model <= 1'b0;
    end else begin
      if (pool_enable && !mute) begin
        pcnt     <= 2'd2;
        pool_res <= max4(pool_in1, pool_in2, pool_in3, pool_in4);
      end else if (pcnt != 2'd0) begin
        pcnt <= pcnt - 2'd1;
      end
      pool_done_model <= (pcnt == 2'd1);
    end
  end

  int errors = 0, checks = 0, done_cnt = 0;
  int exp_rd_q[$];
  logic [4*DATA_W-1:0] exp_pin_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
  logic [4*DATA_W-1:0] last_pin = '0, mon_pin;
  logic [ADDR_W+DATA_W-1:0] mon_wr;
  int mon_rd;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: pop expectations as the DUT produces reads/pool/writes.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rd_en) begin
      if (exp_rd_q.size() == 0) check_eq("rd_unexpected", 128'(rd_en), 128'(0));
      else begin
        mon_rd = exp_rd_q.pop_front();
        check_eq("rd_addr", 128'(rd_addr), 128'(mon_rd));
      end
    end
    if (pool_enable) begin
      if (exp_pin_q.size() == 0) check_eq("pool_en_unexpected", 128'(pool_enable), 128'(0));
      else begin
        last_pin = exp_pin_q.pop_front();
        check_eq("pool_in", 128'({pool_in1, pool_in2, pool_in3, pool_in4}), 128'(last_pin));
      end
    end
    if (wr_en) begin
      $display("wr addr=%0d data=%0h", wr_addr, wr_data);
      check_eq("rd_wr_excl", 128'(rd_en), 128'(0));
      check_eq("pool_in_hold", 128'({pool_in1, pool_in2, pool_in3, pool_in4}), 128'(last_pin));
      if (exp_wr_q.size() == 0) check_eq("wr_unexpected", 128'(wr_en), 128'(0));
      else begin
        mon_wr = exp_wr_q.pop_front();
        check_eq("wr_addr_data", 128'({wr_addr, wr_data}), 128'(mon_wr));
      end
    end
  end

  task automatic push_run(input int zero_win);
    int a0, widx;
    logic [DATA_W-1:0] mx;
    for (int r = 0; r < IMG_H; r += 2) begin
      for (int c = 0; c < IMG_W; c += 2) begin
        a0   = r * IMG_W + c;
        widx = (r / 2) * (IMG_W / 2) + c / 2;
        exp_rd_q.push_back(a0);
        exp_rd_q.push_back(a0 + 1);
        exp_rd_q.push_back(a0 + IMG_W);
        exp_rd_q.push_back(a0 + IMG_W + 1);
        exp_pin_q.push_back({mem[a0], mem[a0+1], mem[a0+IMG_W], mem[a0+IMG_W+1]});
        mx = max4(mem[a0], mem[a0+1], mem[a0+IMG_W], mem[a0+IMG_W+1]);
        if (widx == zero_win) mx = '0;
        exp_wr_q.push_back({ADDR_W'(widx), mx});
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ctrl"}, 128'({busy, done, rd_en, rd_addr, pool_enable, wr_en, wr_addr, err}), 128'(0));
    check_eq({tag, "_data"}, 128'({pool_in1, pool_in2, pool_in3, pool_in4, wr_data}), 128'(0));
  endtask

  // mode: 0 plain, 1 start re-pulses, 2 spurious pool_done, 3 reset in WAIT, 4 mute window 1
  task automatic run_map(input int mode, input int exp_busy);
    int busy_cnt, wr_seen, guard, done_before;
    bit seen_done, aborted, arm;
    busy_cnt = 0; wr_seen = 0; guard = 0; done_before = done_cnt;
    seen_done = 1'b0; aborted = 1'b0; arm = 1'b0;
    @(negedge clk); start = 1'b1;
    while (!seen_done && !aborted && guard < 500) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      pool_done_spur = 1'b0;
      if (busy) busy_cnt++;
      if (wr_en) wr_seen++;
      case (mode)
        1: if (rd_en && rd_addr == 8'd6) start = 1'b1;
        2: if (rd_en && rd_addr == 8'd1) pool_done_spur = 1'b1;
        3: begin
          if (arm) begin rst_n = 1'b0; aborted = 1'b1; end
          else if (pool_enable && wr_seen == 2) arm = 1'b1;
        end
        4: mute = (wr_seen == 1);
        default: ;
      endcase
      if (done) begin
        seen_done = 1'b1;
        if (mode == 1) start = 1'b1;
      end
    end
    if (aborted) begin
      @(negedge clk);
      exp_rd_q.delete(); exp_pin_q.delete(); exp_wr_q.delete();
      check_outputs_zero("abort_zero");
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check_eq("abort_idle_busy", 128'(busy), 128'(0));
      check_eq("abort_no_done", 128'(done_cnt - done_before), 128'(0));
      return;
    end
    check_eq("done_seen", 128'(seen_done), 128'(1));
    check_eq("busy_cycles", 128'(busy_cnt), 128'(exp_busy));
    @(negedge clk); start = 1'b0;
    check_eq("busy_after_done", 128'(busy), 128'(0));
    repeat (4) @(negedge clk);
    check_eq("done_pulses", 128'(done_cnt - done_before), 128'(1));
    check_eq("writes_left", 128'(exp_wr_q.size()), 128'(0));
    check_eq("reads_left", 128'(exp_rd_q.size()), 128'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < NPIX; i++) mem[i] = DATA_W'(i);
    push_run(-1); run_map(0, BUSY_NOM);

    for (int i = 0; i < NPIX; i++) mem[i] = 22'h3FFFFB;
    push_run(-1); run_map(0, BUSY_NOM);

    for (int i = 0; i < NPIX; i++) mem[i] = DATA_W'($urandom);
    push_run(-1); run_map(0, BUSY_NOM);

    for (int i = 0; i < NPIX; i++) mem[i] = DATA_W'(i);
    push_run(-1); run_map(1, BUSY_NOM);

    push_run(-1); run_map(3, 0);
    push_run(-1); run_map(0, BUSY_NOM);

    push_run(-1); run_map(2, BUSY_NOM);
    check_eq("err_clear", 128'(err), 128'(0));

`ifdef MAXPOOL_SEQ_TIMEOUT_EN
    // Window 1: 6 + 16 WAIT + WRITE = 23 cycles instead of 10.
    push_run(1); run_map(4, BUSY_NOM + 13);
    check_eq("err_set", 128'(err), 128'(1));
    push_run(-1); run_map(0, BUSY_NOM);
    check_eq("err_sticky", 128'(err), 128'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
